// File: rtl/reg_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
//
// Purpose : shared types, default sizes and a width helper for the
//           register-bank write-port arbiter (reg_write_arbiter).
// Contents: arb_state_t   - arbiter FSM states
//           NUM_REQ       - default requester count
//           DATA_WIDTH    - default register data width
//           NUM_REGS      - default register count
//           addr_width(n) - index width for n items, never below 1
// ---------------------------------------------------------------------------
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADED  = 2'd1,
        STALLED = 2'd2
    } arb_state_t;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_REGS   = 6;

    // Width of an index able to address n items; a single item still gets a
    // one-bit index so that no zero-width vectors appear anywhere.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter_if
//
// Purpose : bundles the requester handshake and the register-bank write
//           port of reg_write_arbiter.
// Signals : req_valid [NUM_REQ]          per-requester write request
//           req_ready [NUM_REQ]          per-requester accept (combinational)
//           req_addr  [NUM_REQ*AW]       packed register index, i at [i*AW +: AW]
//           req_data  [NUM_REQ*DW]       packed write data, same packing
//           wr_stall                     bank cannot take a write this cycle
//           reg_we    [NUM_REGS]         one-hot write enable to the bank
//           reg_wdata [DATA_WIDTH]       shared write data to the bank
// Modports: master - requesters plus bank side (drives requests and stall)
//           slave  - the arbiter
// ---------------------------------------------------------------------------
interface reg_write_arbiter_if #(
    parameter int NUM_REQ    = reg_arb_pkg::NUM_REQ,
    parameter int DATA_WIDTH = reg_arb_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = reg_arb_pkg::NUM_REGS
);
    import reg_arb_pkg::*;

    localparam int AW = addr_width(NUM_REGS);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*AW-1:0]         req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          wr_stall;
    logic [NUM_REGS-1:0]           reg_we;
    logic [DATA_WIDTH-1:0]         reg_wdata;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        output wr_stall,
        input  req_ready,
        input  reg_we,
        input  reg_wdata
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        input  wr_stall,
        output req_ready,
        output reg_we,
        output reg_wdata
    );

endinterface

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purpose : round-robin selection among N requesters. The search starts at
//           the priority pointer and wraps; the first active request wins.
//           The pointer moves to one past the winner only when the caller
//           signals that the grant was actually used (advance).
// Ports   : clk           clock
//           rst           asynchronous active-high reset (pointer -> 0)
//           req[N]        active requests
//           advance       the current grant was consumed this cycle
//           grant_onehot  one-hot winner (all zero when nothing requests)
//           grant_idx     index of the winner (0 when nothing requests)
// ---------------------------------------------------------------------------
module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = addr_width(N)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;

    // Walk the requesters in priority order starting at the pointer. The
    // candidate index is reduced modulo N with a single subtraction since
    // ptr_q + k never reaches 2*N.
    always_comb begin
        int   idx;
        logic found;
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[IW-1:0]]) begin
                found                      = 1'b1;
                grant_onehot[idx[IW-1:0]]  = 1'b1;
                grant_idx                  = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Purpose : shares the single write port of a register bank between
//           NUM_REQ requesters. A round-robin arbiter picks one valid
//           requester per cycle, the accepted write is captured in a single
//           staging register and, one cycle later, drives a one-hot
//           reg_we line plus the shared reg_wdata bus. wr_stall from the
//           bank freezes the stage and blocks new accepts.
// Ports   : clk          clock, all state changes on the rising edge
//           rst          asynchronous active-high reset
//           bus          reg_write_arbiter_if.slave (requests + bank port)
//           err_clr      clears err_sticky (a coincident new error wins)
//           busy         staging register holds a write
//           err_sticky   an out-of-range register index was accepted
//           write_count  [15:0] saturating count of committed in-range
//                        writes; present only when REG_WRITE_ARB_STATS_EN
//                        is defined
// Options : REG_WRITE_ARB_STATS_EN - adds the write_count output and counter.
// ---------------------------------------------------------------------------
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ    = reg_arb_pkg::NUM_REQ,
    parameter int DATA_WIDTH = reg_arb_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = reg_arb_pkg::NUM_REGS
)(
    input  logic               clk,
    input  logic               rst,
    reg_write_arbiter_if.slave bus,
    input  logic               err_clr,
    output logic               busy,
    output logic               err_sticky
`ifdef REG_WRITE_ARB_STATS_EN
    ,
    output logic [15:0]        write_count
`endif
);

    localparam int AW = addr_width(NUM_REGS);
    localparam int IW = addr_width(NUM_REQ);

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [NUM_REQ-1:0] grant_onehot;
    logic [IW-1:0]      grant_idx;
    logic               accept_ok;
    logic               transfer;

    // -----------------------------------------------------------------------
    // Stage and FSM state
    // -----------------------------------------------------------------------
    arb_state_t            state_q;
    arb_state_t            cur_state;
    logic                  stage_valid;
    logic [NUM_REGS-1:0]   stage_we_q;
    logic [DATA_WIDTH-1:0] stage_data_q;
    logic                  err_q;

    // Unpacked views of the packed request buses, and the winner's fields.
    logic [AW-1:0]         addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [AW-1:0]         win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REGS-1:0]   win_we;
    logic                  win_in_range;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
            assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign win_addr = addr_arr[grant_idx];
    assign win_data = data_arr[grant_idx];

    // Decode the winner's index to one-hot before it is staged, so reg_we
    // comes straight out of a register. An index >= NUM_REGS matches no
    // line and leaves the pattern all zero, which doubles as the range check.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign win_we[gi] = (win_addr == AW'(gi));
        end
    endgenerate

    assign win_in_range = |win_we;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk          (clk),
        .rst          (rst),
        .req          (bus.req_valid),
        .advance      (transfer),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // The register state only tracks whether the stage is occupied; STALLED
    // is that occupancy qualified by the live wr_stall input, because a
    // stall must suppress the write in the very cycle it is raised.
    assign stage_valid = (state_q != IDLE);

    always_comb begin
        cur_state = IDLE;
        if (stage_valid) begin
            cur_state = bus.wr_stall ? STALLED : LOADED;
        end
    end

    // A new write may enter when the stage is empty or is draining this
    // cycle. rst is included so nothing looks accepted while reset is held.
    assign accept_ok     = !rst && (!stage_valid || !bus.wr_stall);
    assign bus.req_ready = accept_ok ? grant_onehot : '0;
    assign transfer      = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            stage_we_q   <= '0;
            stage_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            case (cur_state)
                // Empty, or draining into the bank at this edge: refill if a
                // transfer happens, otherwise the stage empties.
                IDLE, LOADED: begin
                    if (transfer) begin
                        state_q      <= LOADED;
                        stage_we_q   <= win_we;
                        stage_data_q <= win_data;
                    end else begin
                        state_q    <= IDLE;
                        stage_we_q <= '0;
                    end
                end
                // STALLED: the stage holds and no transfer can occur.
                default: begin
                end
            endcase

            if (transfer && !win_in_range) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bank-side outputs
    // -----------------------------------------------------------------------
    assign bus.reg_we    = bus.wr_stall ? '0 : stage_we_q;
    assign bus.reg_wdata = stage_data_q;
    assign busy          = stage_valid;
    assign err_sticky    = err_q;

`ifdef REG_WRITE_ARB_STATS_EN
    // Counts only writes that actually reach the bank: in range and unstalled.
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if ((|bus.reg_we) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign write_count = count_q;
`endif

endmodule
